// File: rtl/sobel_edge_pkg.sv
// Shared edge-detection constants: pixel/window widths, default raster size,
// 3x3 window tap offsets and the pipeline tag carried alongside the data.
package sobel_edge_pkg;

    localparam int PIX_W    = 8;
    localparam int MATRIX_W = 72;
    localparam int COLS_DEF = 640;
    localparam int ROWS_DEF = 480;
    localparam int HC_W     = 11;
    localparam int VC_W     = 10;
    localparam int SUM_W    = 10;
    localparam int CNT_W    = 20;

    localparam int Z0_LSB = 0;
    localparam int Z1_LSB = 8;
    localparam int Z2_LSB = 16;
    localparam int Z3_LSB = 24;
    localparam int Z4_LSB = 32;
    localparam int Z5_LSB = 40;
    localparam int Z6_LSB = 48;
    localparam int Z7_LSB = 56;
    localparam int Z8_LSB = 64;

    typedef struct packed {
        logic            vld;
        logic [HC_W-1:0] h;
        logic [VC_W-1:0] v;
    } tag_t;

    // Zero-extended tap, ready for 10-bit partial-sum arithmetic.
    function automatic logic [SUM_W-1:0] tap(input logic [MATRIX_W-1:0] m, input int lsb);
        return {{(SUM_W-PIX_W){1'b0}}, m[lsb +: PIX_W]};
    endfunction

endpackage

// File: rtl/sobel_edge_absdiff.sv
// Absolute difference of two unsigned 10-bit partial sums (|a - b|).
module sobel_absdiff
    import sobel_edge_pkg::*;
(
    input  logic [SUM_W-1:0] a,
    input  logic [SUM_W-1:0] b,
    output logic [SUM_W-1:0] y
);

    always_comb begin
        y = (a >= b) ? (a - b) : (b - a);
    end

endmodule

// File: rtl/sobel_edge.sv
// 3-stage Sobel gradient magnitude with edge threshold and per-frame edge count.
// The edge flag port is named edge_flag because "edge" is a reserved word.
module sobel_edge
    import sobel_edge_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int THRESH_RST = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [MATRIX_W-1:0] matrix,
    input  logic                in_valid,
    input  logic [HC_W-1:0]     hcount,
    input  logic [VC_W-1:0]     vcount,
    input  logic [PIX_W-1:0]    threshold,
    output logic [PIX_W-1:0]    out_pixel,
    output logic                edge_flag,
    output logic                out_valid,
    output logic [HC_W-1:0]     out_hcount,
    output logic [VC_W-1:0]     out_vcount,
    output logic [CNT_W-1:0]    frame_edges
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SUM_W-1:0] gx_p_q, gx_n_q, gy_p_q, gy_n_q;
    logic [SUM_W-1:0] gx_p_d, gx_n_d, gy_p_d, gy_n_d;
    tag_t             s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
    logic [SUM_W-1:0] abs_gx_q, abs_gy_q, abs_gx_d, abs_gy_d;
    logic [PIX_W-1:0] thresh_q, thresh_d;
    logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
    logic             edge_q, edge_d;
    logic             out_valid_q, out_valid_d;
    logic [HC_W-1:0]  out_hcount_q, out_hcount_d;
    logic [VC_W-1:0]  out_vcount_q, out_vcount_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, frame_edges_q, frame_edges_d;

    logic             accept;
    logic [HC_W-1:0]  mag;
    logic             border, inc;
    logic [PIX_W-1:0] pix;
    logic [CNT_W-1:0] cnt_sum;

    // S1: partial sums and input qualification
    always_comb begin
        gx_p_d   = tap(matrix, Z8_LSB) + (tap(matrix, Z5_LSB) << 1) + tap(matrix, Z2_LSB);
        gx_n_d   = tap(matrix, Z6_LSB) + (tap(matrix, Z3_LSB) << 1) + tap(matrix, Z0_LSB);
        gy_p_d   = tap(matrix, Z8_LSB) + (tap(matrix, Z7_LSB) << 1) + tap(matrix, Z6_LSB);
        gy_n_d   = tap(matrix, Z2_LSB) + (tap(matrix, Z1_LSB) << 1) + tap(matrix, Z0_LSB);
        accept   = in_valid && (hcount < HC_W'(COLS)) && (vcount < VC_W'(ROWS));
        s1_tag_d = '{vld: accept, h: hcount, v: vcount};
        thresh_d = (accept && hcount == '0 && vcount == '0) ? threshold : thresh_q;
    end

    // S2: |Gx| and |Gy|
    sobel_absdiff u_abs_gx (.a(gx_p_q), .b(gx_n_q), .y(abs_gx_d));
    sobel_absdiff u_abs_gy (.a(gy_p_q), .b(gy_n_q), .y(abs_gy_d));

    always_comb begin
        s2_tag_d = s1_tag_q;
    end

    // S3: saturate, threshold, border blanking and edge accounting
    always_comb begin
        mag     = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};
        border  = (s2_tag_q.h < HC_W'(2)) || (s2_tag_q.v < VC_W'(2));
        pix     = border ? '0 : ((mag > HC_W'(255)) ? '1 : mag[PIX_W-1:0]);
        inc     = s2_tag_q.vld && !border && (pix >= thresh_q);
        cnt_sum = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(inc);

        out_valid_d   = s2_tag_q.vld;
        out_pixel_d   = out_pixel_q;
        edge_d        = edge_q;
        out_hcount_d  = out_hcount_q;
        out_vcount_d  = out_vcount_q;
        cnt_d         = cnt_sum;
        frame_edges_d = frame_edges_q;

        if (s2_tag_q.vld) begin
            out_pixel_d  = pix;
            edge_d       = inc;
            out_hcount_d = s2_tag_q.h;
            out_vcount_d = s2_tag_q.v;
            // Frame-start pixel closes the old frame and opens the new one.
            if (s2_tag_q.h == '0 && s2_tag_q.v == '0) begin
                frame_edges_d = cnt_sum;
                cnt_d         = CNT_W'(inc);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gx_p_q        <= '0;
            gx_n_q        <= '0;
            gy_p_q        <= '0;
            gy_n_q        <= '0;
            s1_tag_q      <= '0;
            s2_tag_q      <= '0;
            abs_gx_q      <= '0;
            abs_gy_q      <= '0;
            thresh_q      <= PIX_W'(THRESH_RST);
            out_pixel_q   <= '0;
            edge_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_hcount_q  <= '0;
            out_vcount_q  <= '0;
            cnt_q         <= '0;
            frame_edges_q <= '0;
        end else begin
            gx_p_q        <= gx_p_d;
            gx_n_q        <= gx_n_d;
            gy_p_q        <= gy_p_d;
            gy_n_q        <= gy_n_d;
            s1_tag_q      <= s1_tag_d;
            s2_tag_q      <= s2_tag_d;
            abs_gx_q      <= abs_gx_d;
            abs_gy_q      <= abs_gy_d;
            thresh_q      <= thresh_d;
            out_pixel_q   <= out_pixel_d;
            edge_q        <= edge_d;
            out_valid_q   <= out_valid_d;
            out_hcount_q  <= out_hcount_d;
            out_vcount_q  <= out_vcount_d;
            cnt_q         <= cnt_d;
            frame_edges_q <= frame_edges_d;
        end
    end

    assign out_pixel   = out_pixel_q;
    assign edge_flag   = edge_q;
    assign out_valid   = out_valid_q;
    assign out_hcount  = out_hcount_q;
    assign out_vcount  = out_vcount_q;
    assign frame_edges = frame_edges_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge: latency, magnitude, border/blanking,
// threshold framing, frame edge counting and mid-stream reset.
module tb_sobel_edge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [71:0] matrix = '0;
    logic        in_valid = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [7:0]  threshold = 8'd64;
    logic [7:0]  out_pixel;
    logic        edge_flag;
    logic        out_valid;
    logic [10:0] out_hcount;
    logic [9:0]  out_vcount;
    logic [19:0] frame_edges;

    int checks = 0;
    int errors = 0;

    sobel_edge dut (
        .clock(clock), .reset(reset), .matrix(matrix), .in_valid(in_valid),
        .hcount(hcount), .vcount(vcount), .threshold(threshold),
        .out_pixel(out_pixel), .edge_flag(edge_flag), .out_valid(out_valid),
        .out_hcount(out_hcount), .out_vcount(out_vcount), .frame_edges(frame_edges)
    );

    always #5 clock = ~clock;

    function automatic logic [71:0] tp(input int idx, input logic [7:0] val);
        logic [71:0] m;
        m = '0;
        m[idx*8 +: 8] = val;
        return m;
    endfunction

    function automatic logic [71:0] rcol(input logic [7:0] val);
        return tp(8, val) | tp(5, val) | tp(2, val);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [71:0] m, input int h, input int v, input logic [7:0] th);
        matrix    = m;
        hcount    = 11'(h);
        vcount    = 10'(v);
        threshold = th;
        in_valid  = 1'b1;
    endtask

    // One pixel followed by bubbles; its result is visible on return.
    task automatic single(input logic [71:0] m, input int h, input int v, input logic [7:0] th);
        drive(m, h, v, th);
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
    endtask

    logic [71:0] u80;
    logic [71:0] smat [5];
    logic [7:0]  spix [5];
    logic        sedg [5];

    initial begin
        u80 = {9{8'h80}};
        smat[0] = tp(8, 8'd30);  spix[0] = 8'd60;  sedg[0] = 1'b1;
        smat[1] = tp(0, 8'd30);  spix[1] = 8'd60;  sedg[1] = 1'b1;
        smat[2] = tp(7, 8'd50);  spix[2] = 8'd100; sedg[2] = 1'b1;
        smat[3] = tp(3, 8'd5);   spix[3] = 8'd10;  sedg[3] = 1'b0;
        smat[4] = tp(6, 8'd255); spix[4] = 8'd255; sedg[4] = 1'b1;

        cyc();
        cyc();
        chk("rst_valid", out_valid, 0);
        chk("rst_pixel", out_pixel, 0);
        chk("rst_edge", edge_flag, 0);
        chk("rst_hcount", out_hcount, 0);
        chk("rst_frame_edges", frame_edges, 0);
        reset = 1'b0;

        single(u80, 0, 0, 8'd64);
        chk("sof_valid", out_valid, 1);
        chk("sof_pixel", out_pixel, 0);
        chk("sof_frame_edges", frame_edges, 0);

        // Flat window; also confirms output is not early.
        drive(u80, 100, 100, 8'd64);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("lat_not_early", out_valid, 0);
        cyc();
        chk("flat_valid", out_valid, 1);
        chk("flat_pixel", out_pixel, 0);
        chk("flat_edge", edge_flag, 0);
        chk("flat_hcount", out_hcount, 100);
        chk("flat_vcount", out_vcount, 100);

        single(rcol(8'd255), 100, 100, 8'd64);
        chk("sat_pixel", out_pixel, 255);
        chk("sat_edge", edge_flag, 1);

        single(rcol(8'd10), 100, 100, 8'd64);
        chk("mag40_pixel", out_pixel, 40);
        chk("mag40_edge_th64", edge_flag, 0);
        single(rcol(8'd10), 101, 100, 8'd20);
        chk("midframe_th_edge", edge_flag, 0);
        single(u80, 0, 0, 8'd20);
        chk("sof2_frame_edges", frame_edges, 1);
        single(rcol(8'd10), 100, 100, 8'd20);
        chk("newframe_th_edge", edge_flag, 1);
        chk("newframe_pixel", out_pixel, 40);

        single(rcol(8'd255), 1, 100, 8'd20);
        chk("h1_valid", out_valid, 1);
        chk("h1_pixel", out_pixel, 0);
        chk("h1_edge", edge_flag, 0);
        single(rcol(8'd255), 100, 1, 8'd20);
        chk("v1_valid", out_valid, 1);
        chk("v1_pixel", out_pixel, 0);
        chk("v1_edge", edge_flag, 0);
        single(rcol(8'd255), 700, 100, 8'd20);
        chk("h700_valid", out_valid, 0);
        chk("hold_pixel", out_pixel, 0);
        chk("hold_hcount", out_hcount, 100);
        chk("hold_vcount", out_vcount, 1);
        single(rcol(8'd255), 100, 480, 8'd20);
        chk("v480_valid", out_valid, 0);

        // Back-to-back stream, 4 of 5 pixels are edges.
        for (int k = 0; k < 7; k++) begin
            if (k < 5) drive(smat[k], 10 + k, 20, 8'd20);
            else in_valid = 1'b0;
            cyc();
            if (k >= 2) begin
                chk("strm_valid", out_valid, 1);
                chk("strm_pixel", out_pixel, spix[k-2]);
                chk("strm_edge", edge_flag, sedg[k-2]);
                chk("strm_hcount", out_hcount, 10 + k - 2);
            end
        end
        single(u80, 0, 0, 8'd20);
        chk("frame_edges_5", frame_edges, 5);
        single(rcol(8'd255), 50, 50, 8'd20);
        single(u80, 0, 0, 8'd20);
        chk("frame_edges_restart", frame_edges, 1);

        // Reset with three inputs in flight.
        drive(rcol(8'd255), 100, 100, 8'd20);
        cyc();
        drive(rcol(8'd255), 101, 100, 8'd20);
        cyc();
        drive(rcol(8'd255), 102, 100, 8'd20);
        cyc();
        reset    = 1'b1;
        in_valid = 1'b0;
        cyc();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_frame_edges", frame_edges, 0);
        chk("mid_rst_pixel", out_pixel, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("discard_valid", out_valid, 0);
        end
        drive(rcol(8'd10), 100, 100, 8'd20);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("post_rst_not_early", out_valid, 0);
        cyc();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_pixel", out_pixel, 40);
        chk("post_rst_th64_edge", edge_flag, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
